// File: rtl/sweep_acq_pkg.sv
// Shared state encoding and framing constants for the sweep-acquisition sequencer.
// Pure declarations: no latency, no backpressure.
package sweep_acq_pkg;

  localparam int DAC_W = 10;

  localparam logic [15:0] HEADER_WORD_DEF  = 16'h5A5A;
  localparam logic [15:0] TRAILER_WORD_DEF = 16'hA5A5;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    WAIT_LOAD,
    SETTLE,
    HDR0,
    HDR1,
    ACQ,
    NEXT,
    TRAIL,
    DONE
  } state_e;

endpackage

// File: rtl/sweep_dac_stepper.sv
// Holds sweep bounds and the current DAC code; DAC updates one cycle after latch/advance.
// No backpressure: advance is ignored on the last point so the code never wraps.
module sweep_dac_stepper
  import sweep_acq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             latch_i,
  input  logic             advance_i,
  input  logic [DAC_W-1:0] start_i,
  input  logic [DAC_W-1:0] end_i,
  input  logic [DAC_W-1:0] step_i,
  output logic [DAC_W-1:0] dac_o,
  output logic             last_o
);

  logic [DAC_W-1:0] dac_q, dac_d;
  logic [DAC_W-1:0] end_q, end_d;
  logic [DAC_W-1:0] step_q, step_d;
  logic [DAC_W:0]   sum;

  // 11-bit sum so a step past 1023 is seen as beyond the end instead of wrapping
  assign sum    = {1'b0, dac_q} + {1'b0, step_q};
  assign last_o = (dac_q >= end_q) || (sum > {1'b0, end_q});
  assign dac_o  = dac_q;

  always_comb begin
    dac_d  = dac_q;
    end_d  = end_q;
    step_d = step_q;
    if (latch_i) begin
      dac_d  = start_i;
      end_d  = end_i;
      step_d = (step_i == '0) ? {{(DAC_W-1){1'b0}}, 1'b1} : step_i;
    end else if (advance_i && !last_o) begin
      dac_d = sum[DAC_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dac_q  <= '0;
      end_q  <= '0;
      step_q <= '0;
    end else begin
      dac_q  <= dac_d;
      end_q  <= end_d;
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/sweep_acq_controller.sv
// Sweep sequencer: per DAC point, SC load, settle, header, N data words; trailer at end.
// Data forwarded with 1-cycle registered latency; every FIFO write stalls (or drops, in ACQ) on UsbFifoFull.
module sweep_acq_controller
  import sweep_acq_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYCLES = 16'd1000,
  parameter logic [15:0] HEADER_WORD   = HEADER_WORD_DEF,
  parameter logic [15:0] TRAILER_WORD  = TRAILER_WORD_DEF
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             SweepStart,
  input  logic [DAC_W-1:0] StartDac,
  input  logic [DAC_W-1:0] EndDac,
  input  logic [DAC_W-1:0] DacStep,
  input  logic [15:0]      WordsPerPoint,
  input  logic             SCLoadDone,
  input  logic [15:0]      ParallelData,
  input  logic             ParallelData_en,
  input  logic             UsbFifoFull,
  output logic [DAC_W-1:0] SweepAcq10BitDac,
  output logic             SweepAcqMicrorocSCParameterLoad,
  output logic             SweepAcqMicrorocAcqStartStop,
  output logic [15:0]      SweepAcqData,
  output logic             SweepAcqData_en,
  output logic             SweepTestUsbStartStop,
  output logic             SweepAcqDone,
  output logic             Overflow
);

  state_e      state_q, state_d;
  logic        start_q;
  logic [15:0] wpp_q, wpp_d;
  logic [15:0] settle_q, settle_d;
  logic [15:0] words_q, words_d;
  logic [15:0] words_inc;
  logic [16:0] settle_inc;
  logic        sc_load_q, sc_load_d;
  logic        acq_q, acq_d;
  logic [15:0] data_q, data_d;
  logic        data_en_q, data_en_d;
  logic        usb_q, usb_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        rise, latch, advance, last;
  logic [DAC_W-1:0] dac;

  sweep_dac_stepper u_stepper (
    .clk_i     (Clk),
    .rst_i     (reset),
    .latch_i   (latch),
    .advance_i (advance),
    .start_i   (StartDac),
    .end_i     (EndDac),
    .step_i    (DacStep),
    .dac_o     (dac),
    .last_o    (last)
  );

  assign rise       = SweepStart && !start_q;
  assign words_inc  = words_q + 16'd1;
  assign settle_inc = {1'b0, settle_q} + 17'd1;

  always_comb begin
    state_d   = state_q;
    wpp_d     = wpp_q;
    settle_d  = settle_q;
    words_d   = words_q;
    sc_load_d = 1'b0;
    acq_d     = acq_q;
    data_d    = data_q;
    data_en_d = 1'b0;
    usb_d     = usb_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    latch     = 1'b0;
    advance   = 1'b0;
    // Dropping SweepStart mid-sweep abandons the record without a trailer
    if (state_q != IDLE && state_q != DONE && !SweepStart) begin
      state_d = IDLE;
      acq_d   = 1'b0;
      usb_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (rise) begin
          latch     = 1'b1;
          wpp_d     = WordsPerPoint;
          usb_d     = 1'b1;
          ovf_d     = 1'b0;
          sc_load_d = 1'b1;
          state_d   = LOAD;
        end
        LOAD: state_d = WAIT_LOAD;
        WAIT_LOAD: if (SCLoadDone) begin
          settle_d = '0;
          state_d  = SETTLE;
        end
        SETTLE: begin
          if (settle_inc >= {1'b0, SETTLE_CYCLES}) state_d = HDR0;
          else settle_d = settle_inc[15:0];
        end
        HDR0: if (!UsbFifoFull) begin
          data_d    = HEADER_WORD;
          data_en_d = 1'b1;
          state_d   = HDR1;
        end
        HDR1: if (!UsbFifoFull) begin
          data_d    = {{(16-DAC_W){1'b0}}, dac};
          data_en_d = 1'b1;
          words_d   = '0;
          if (wpp_q == '0) begin
            state_d = NEXT;
          end else begin
            acq_d   = 1'b1;
            state_d = ACQ;
          end
        end
        ACQ: if (ParallelData_en) begin
          if (UsbFifoFull) begin
            ovf_d = 1'b1;
          end else begin
            data_d    = ParallelData;
            data_en_d = 1'b1;
            words_d   = words_inc;
            if (words_inc == wpp_q) begin
              acq_d   = 1'b0;
              state_d = NEXT;
            end
          end
        end
        NEXT: begin
          if (last) begin
            state_d = TRAIL;
          end else begin
            advance   = 1'b1;
            sc_load_d = 1'b1;
            state_d   = LOAD;
          end
        end
        TRAIL: if (!UsbFifoFull) begin
          data_d    = TRAILER_WORD;
          data_en_d = 1'b1;
          done_d    = 1'b1;
          state_d   = DONE;
        end
        DONE: if (!SweepStart) begin
          done_d  = 1'b0;
          usb_d   = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Edge detector tracks the level through reset so a held-high start never re-triggers
  always_ff @(posedge Clk) begin
    start_q <= SweepStart;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wpp_q     <= '0;
      settle_q  <= '0;
      words_q   <= '0;
      sc_load_q <= 1'b0;
      acq_q     <= 1'b0;
      data_q    <= '0;
      data_en_q <= 1'b0;
      usb_q     <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wpp_q     <= wpp_d;
      settle_q  <= settle_d;
      words_q   <= words_d;
      sc_load_q <= sc_load_d;
      acq_q     <= acq_d;
      data_q    <= data_d;
      data_en_q <= data_en_d;
      usb_q     <= usb_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign SweepAcq10BitDac                = dac;
  assign SweepAcqMicrorocSCParameterLoad = sc_load_q;
  assign SweepAcqMicrorocAcqStartStop    = acq_q;
  assign SweepAcqData                    = data_q;
  assign SweepAcqData_en                 = data_en_q;
  assign SweepTestUsbStartStop           = usb_q;
  assign SweepAcqDone                    = done_q;
  assign Overflow                        = ovf_q;

endmodule

// File: tb/tb_sweep_acq_controller.sv
// Randomized bench for sweep_acq_controller: a point-list model of each sweep predicts the FIFO record.
// Drives a stubbed Microroc (SC done, data strobes) and a randomly-full USB FIFO.
module tb_sweep_acq_controller;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        SweepStart = 1'b0;
  logic [9:0]  StartDac = '0;
  logic [9:0]  EndDac = '0;
  logic [9:0]  DacStep = '0;
  logic [15:0] WordsPerPoint = '0;
  logic        SCLoadDone = 1'b0;
  logic [15:0] ParallelData = '0;
  logic        ParallelData_en = 1'b0;
  logic        UsbFifoFull = 1'b0;
  logic [9:0]  SweepAcq10BitDac;
  logic        SweepAcqMicrorocSCParameterLoad;
  logic        SweepAcqMicrorocAcqStartStop;
  logic [15:0] SweepAcqData;
  logic        SweepAcqData_en;
  logic        SweepTestUsbStartStop;
  logic        SweepAcqDone;
  logic        Overflow;

  always #5 Clk = ~Clk;

  sweep_acq_controller #(.SETTLE_CYCLES(16'd10)) dut (
    .Clk                             (Clk),
    .reset                           (reset),
    .SweepStart                      (SweepStart),
    .StartDac                        (StartDac),
    .EndDac                          (EndDac),
    .DacStep                         (DacStep),
    .WordsPerPoint                   (WordsPerPoint),
    .SCLoadDone                      (SCLoadDone),
    .ParallelData                    (ParallelData),
    .ParallelData_en                 (ParallelData_en),
    .UsbFifoFull                     (UsbFifoFull),
    .SweepAcq10BitDac                (SweepAcq10BitDac),
    .SweepAcqMicrorocSCParameterLoad (SweepAcqMicrorocSCParameterLoad),
    .SweepAcqMicrorocAcqStartStop    (SweepAcqMicrorocAcqStartStop),
    .SweepAcqData                    (SweepAcqData),
    .SweepAcqData_en                 (SweepAcqData_en),
    .SweepTestUsbStartStop           (SweepTestUsbStartStop),
    .SweepAcqDone                    (SweepAcqDone),
    .Overflow                        (Overflow)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] fifo_q[$];
  logic [15:0] acc_q[$];
  int          sc_q[$];
  int          pts[$];
  bit          full_prev = 1'b0;
  bit          ld_armed = 1'b0;
  int          ld_wait = 0;
  int          full_burst = 0;
  bit          burst_mode = 1'b0;
  bit          acq_prev = 1'b0;
  int          pt_words = 0;
  int          wpp_cur = 0;
  bit          ovf_exp = 1'b0;
  bit          ld_fired = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: observe outputs just after the edge, then drive inputs for the next edge.
  task automatic tick();
    @(posedge Clk);
    #1;
    if (SweepAcqData_en) begin
      fifo_q.push_back(SweepAcqData);
      chk("write_while_full", {31'd0, full_prev}, 32'd0);
    end
    if (SweepAcqMicrorocSCParameterLoad) begin
      sc_q.push_back(int'(SweepAcq10BitDac));
      ld_armed = 1'b1;
      ld_wait  = $urandom_range(1, 4);
    end
    if (SweepAcqMicrorocAcqStartStop && !acq_prev) begin
      pt_words = 0;
      if (burst_mode) full_burst = 20;
    end
    acq_prev = SweepAcqMicrorocAcqStartStop;

    SCLoadDone = 1'b0;
    if (ld_armed) begin
      if (ld_wait == 0) begin
        SCLoadDone = 1'b1;
        ld_armed   = 1'b0;
        ld_fired   = 1'b1;
        if (burst_mode) full_burst = 20;
      end else begin
        ld_wait--;
      end
    end else begin
      SCLoadDone = ($urandom_range(0, 15) == 0);
    end

    if (full_burst > 0) begin
      UsbFifoFull = 1'b1;
      full_burst--;
    end else begin
      UsbFifoFull = ($urandom_range(0, 5) == 0);
    end

    ParallelData = 16'($urandom);
    if (SweepAcqMicrorocAcqStartStop) begin
      ParallelData_en = (pt_words < wpp_cur) && ($urandom_range(0, 3) != 0);
      if (ParallelData_en) begin
        if (UsbFifoFull) begin
          ovf_exp = 1'b1;
        end else begin
          acc_q.push_back(ParallelData);
          pt_words++;
        end
      end
    end else begin
      ParallelData_en = ($urandom_range(0, 3) == 0);
    end
    full_prev = UsbFifoFull;
  endtask

  task automatic build_points(input int s, input int e, input int st);
    int stp;
    int p;
    stp = (st == 0) ? 1 : st;
    p = s;
    pts.delete();
    forever begin
      pts.push_back(p);
      if (p >= e || p + stp > e) break;
      p += stp;
    end
  endtask

  task automatic begin_sweep(input int s, input int e, input int st, input int w, input bit burst);
    SweepStart = 1'b0;
    tick();
    tick();
    fifo_q.delete();
    acc_q.delete();
    sc_q.delete();
    ld_armed   = 1'b0;
    ld_fired   = 1'b0;
    full_burst = 0;
    burst_mode = burst;
    wpp_cur    = w;
    ovf_exp    = 1'b0;
    pt_words   = 0;
    StartDac      = 10'(s);
    EndDac        = 10'(e);
    DacStep       = 10'(st);
    WordsPerPoint = 16'(w);
    SweepStart = 1'b1;
    tick();
    // the sweep must run on the values captured at the start edge
    StartDac      = 10'($urandom);
    EndDac        = 10'($urandom);
    DacStep       = 10'($urandom);
    WordsPerPoint = 16'($urandom_range(0, 9));
  endtask

  task automatic run_sweep(input int s, input int e, input int st, input int w, input bit burst);
    logic [15:0] exp_q[$];
    int idx;
    int budget;
    begin_sweep(s, e, st, w, burst);
    budget = 0;
    while (!SweepAcqDone && budget < 20000) begin
      tick();
      budget++;
    end
    chk("sweep_done", {31'd0, SweepAcqDone}, 32'd1);

    build_points(s, e, st);
    idx = 0;
    foreach (pts[i]) begin
      exp_q.push_back(16'h5A5A);
      exp_q.push_back(16'(pts[i]));
      for (int k = 0; k < w; k++) begin
        exp_q.push_back((idx < acc_q.size()) ? acc_q[idx] : 16'hDEAD);
        idx++;
      end
    end
    exp_q.push_back(16'hA5A5);

    chk("fifo_len", fifo_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < fifo_q.size(); i++)
      chk("fifo_word", {16'd0, fifo_q[i]}, {16'd0, exp_q[i]});
    chk("sc_pulses", sc_q.size(), pts.size());
    for (int i = 0; i < pts.size() && i < sc_q.size(); i++)
      chk("sc_dac", sc_q[i], pts[i]);
    chk("words_driven", acc_q.size(), pts.size() * w);
    chk("final_dac", {22'd0, SweepAcq10BitDac}, pts[pts.size()-1]);
    chk("overflow", {31'd0, Overflow}, {31'd0, ovf_exp});
    chk("usb_in_done", {31'd0, SweepTestUsbStartStop}, 32'd1);
    chk("acq_in_done", {31'd0, SweepAcqMicrorocAcqStartStop}, 32'd0);

    SweepStart = 1'b0;
    tick();
    chk("done_clear", {31'd0, SweepAcqDone}, 32'd0);
    chk("usb_clear", {31'd0, SweepTestUsbStartStop}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {22'd0, SweepAcq10BitDac}, 32'd0);
    chk(tag, {31'd0, SweepAcqMicrorocSCParameterLoad}, 32'd0);
    chk(tag, {31'd0, SweepAcqMicrorocAcqStartStop}, 32'd0);
    chk(tag, {16'd0, SweepAcqData}, 32'd0);
    chk(tag, {31'd0, SweepAcqData_en}, 32'd0);
    chk(tag, {31'd0, SweepTestUsbStartStop}, 32'd0);
    chk(tag, {31'd0, SweepAcqDone}, 32'd0);
    chk(tag, {31'd0, Overflow}, 32'd0);
  endtask

  initial begin
    int budget;
    int n0;
    logic [9:0] dac_before;
    int s;
    int e;

    reset = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset_state");
    reset = 1'b0;

    run_sweep(100, 110, 5, 3, 1'b0);
    run_sweep(1020, 1023, 10, 2, 1'b0);
    run_sweep(100, 110, 5, 3, 1'b1);
    run_sweep(7, 7, 0, 0, 1'b0);
    run_sweep(50, 20, 3, 2, 1'b0);

    // abort while acquiring
    begin_sweep(200, 212, 4, 5, 1'b0);
    budget = 0;
    while (!SweepAcqMicrorocAcqStartStop && budget < 2000) begin
      tick();
      budget++;
    end
    chk("abort_reached_acq", {31'd0, SweepAcqMicrorocAcqStartStop}, 32'd1);
    dac_before = SweepAcq10BitDac;
    SweepStart = 1'b0;
    tick();
    chk("abort_acq", {31'd0, SweepAcqMicrorocAcqStartStop}, 32'd0);
    chk("abort_usb", {31'd0, SweepTestUsbStartStop}, 32'd0);
    chk("abort_data_en", {31'd0, SweepAcqData_en}, 32'd0);
    ld_armed = 1'b0;
    n0 = fifo_q.size();
    repeat (30) tick();
    chk("abort_no_writes", fifo_q.size(), n0);
    chk("abort_done", {31'd0, SweepAcqDone}, 32'd0);
    chk("abort_dac_hold", {22'd0, SweepAcq10BitDac}, {22'd0, dac_before});
    run_sweep(200, 212, 4, 5, 1'b0);

    // reset while settling, with SweepStart still high
    begin_sweep(300, 310, 5, 2, 1'b0);
    budget = 0;
    while (!ld_fired && budget < 200) begin
      tick();
      budget++;
    end
    chk("reached_settle", {31'd0, ld_fired}, 32'd1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk_all_zero("reset_in_settle");
    reset = 1'b0;
    ld_armed = 1'b0;
    sc_q.delete();
    n0 = fifo_q.size();
    repeat (40) tick();
    chk("no_restart_sc", sc_q.size(), 0);
    chk("no_restart_usb", {31'd0, SweepTestUsbStartStop}, 32'd0);
    chk("no_restart_writes", fifo_q.size(), n0);

    for (int r = 0; r < 6; r++) begin
      s = $urandom_range(0, 1023);
      if ($urandom_range(0, 4) == 0) e = $urandom_range(0, s);
      else e = (s + $urandom_range(0, 40) > 1023) ? 1023 : s + $urandom_range(0, 40);
      run_sweep(s, e, $urandom_range(0, 8), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
